mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bundle for mem_port_arbiter.
// slave: arbiter view; master: clients plus memory instance.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  mem_we;
  logic [AW-1:0]         mem_wraddr;
  logic [DW-1:0]         mem_din;
  logic [AW-1:0]         mem_rdaddr;
  logic [DW-1:0]         mem_q;
  logic                  rd_busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_data,
    output mem_we, mem_wraddr, mem_din, mem_rdaddr, rd_busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_we, mem_wraddr, mem_din, mem_rdaddr, rd_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of a dual-port memory's write and read ports.
// Optional MEM_ARB_RAW_STALL_EN holds reads to recently written addresses.
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int MEM_RD_LATENCY = 2,
  parameter int MEM_WR_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TD = MEM_RD_LATENCY + 1;

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [NUM_REQ-1:0] wr_cand, rd_cand, rd_mask;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [PW-1:0]      wr_idx, rd_idx;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [DW-1:0]      wr_data;

  logic               we_q;
  logic [AW-1:0]      wraddr_q, rdaddr_q;
  logic [DW-1:0]      din_q, rsp_data_q;
  logic [TD-1:0]      tag_v;
  logic [PW-1:0]      tag_id [TD];
  logic [NUM_REQ-1:0] rsp_oh;

  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] cand,
    input logic [PW-1:0]      ptr
  );
    logic [NUM_REQ-1:0] g;
    logic               hit;
    int                 idx;
    g   = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && cand[idx[PW-1:0]]) begin
        g[idx[PW-1:0]] = 1'b1;
        hit            = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] enc(input logic [NUM_REQ-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) r = r | PW'(i);
    return r;
  endfunction

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_cand = bus.req_valid & bus.req_we;
    wr_gnt  = rr_pick(wr_cand, wr_ptr);
    wr_idx  = enc(wr_gnt);
    wr_addr = bus.req_addr[int'(wr_idx)*AW +: AW];
    wr_data = bus.req_wdata[int'(wr_idx)*DW +: DW];
  end

`ifdef MEM_ARB_RAW_STALL_EN
  localparam int HD = MEM_WR_LATENCY + 1;

  logic [HD-1:0] hist_v;
  logic [AW-1:0] hist_a [HD];

  // Hazard window: this cycle's writer plus the last HD accepted writes.
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (|wr_gnt && bus.req_addr[i*AW +: AW] == wr_addr)
        rd_mask[i] = 1'b1;
      for (int k = 0; k < HD; k++)
        if (hist_v[k] && hist_a[k] == bus.req_addr[i*AW +: AW])
          rd_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_v <= '0;
      for (int k = 0; k < HD; k++) hist_a[k] <= '0;
    end else begin
      hist_v    <= {hist_v[HD-2:0], |wr_gnt};
      hist_a[0] <= wr_addr;
      for (int k = 1; k < HD; k++) hist_a[k] <= hist_a[k-1];
    end
  end
`else
  assign rd_mask = '0;
`endif

  always_comb begin
    rd_cand = bus.req_valid & ~bus.req_we & ~rd_mask;
    rd_gnt  = rr_pick(rd_cand, rd_ptr);
    rd_idx  = enc(rd_gnt);
    rd_addr = bus.req_addr[int'(rd_idx)*AW +: AW];
  end

  assign bus.req_ready = wr_gnt | rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      we_q     <= 1'b0;
      wraddr_q <= '0;
      din_q    <= '0;
      rdaddr_q <= '0;
    end else begin
      we_q <= |wr_gnt;
      if (|wr_gnt) begin
        wr_ptr   <= inc(wr_idx);
        wraddr_q <= wr_addr;
        din_q    <= wr_data;
      end
      if (|rd_gnt) begin
        rd_ptr   <= inc(rd_idx);
        rdaddr_q <= rd_addr;
      end
    end
  end

  // Stage TD-2 lines up with the matching mem_q, stage TD-1 with rsp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v      <= '0;
      rsp_data_q <= '0;
      for (int k = 0; k < TD; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[TD-2:0], |rd_gnt};
      tag_id[0] <= rd_idx;
      for (int k = 1; k < TD; k++) tag_id[k] <= tag_id[k-1];
      if (tag_v[TD-2]) rsp_data_q <= bus.mem_q;
    end
  end

  always_comb begin
    rsp_oh = '0;
    if (tag_v[TD-1]) rsp_oh[tag_id[TD-1]] = 1'b1;
  end

  assign bus.mem_we     = we_q;
  assign bus.mem_wraddr = wraddr_q;
  assign bus.mem_din    = din_q;
  assign bus.mem_rdaddr = rdaddr_q;
  assign bus.rsp_valid  = rsp_oh;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rd_busy    = |tag_v;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a cycle-level model.
// Honors MEM_ARB_RAW_STALL_EN the same way as the design build.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int WL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(N), .AW(AW), .DW(DW),
    .MEM_RD_LATENCY(RL), .MEM_WR_LATENCY(WL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory instance: write lands two cycles after mem_we, read data one
  // cycle after mem_rdaddr (captured into rsp_data one cycle later).
  bit [DW-1:0]   mem_arr [2**AW];
  logic          wp_we = 1'b0;
  logic [AW-1:0] wp_a  = '0;
  logic [DW-1:0] wp_d  = '0;
  always @(posedge clk) begin
    wp_we <= bus.mem_we;
    wp_a  <= bus.mem_wraddr;
    wp_d  <= bus.mem_din;
    if (wp_we === 1'b1) mem_arr[wp_a] <= wp_d;
    bus.mem_q <= mem_arr[bus.mem_rdaddr];
  end

  logic          v  [N];
  logic          we [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wlog [$];
  int            rq [$];
  int            rsp_id [int];
  logic [DW-1:0] rsp_dat [int];
  int            cyc = 0;
  int            last_rst = 0;
  int            wptr = 0;
  int            rptr = 0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_wa = '0;
  logic [AW-1:0] exp_ra = '0;
  logic [DW-1:0] exp_wd = '0;
  int            nrun = 0;
  int            nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = v[i];
      bus.req_we[i]                = we[i];
      bus.req_addr[i*AW +: AW]     = ad[i];
      bus.req_wdata[i*DW +: DW]    = wd[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] cand, input int ptr);
    for (int k = 0; k < N; k++)
      if (cand[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Memory content seen by a read accepted in cycle c.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a,
                                             input int c);
    logic [DW-1:0] r;
    r = '0;
    foreach (wlog[k])
      if (wlog[k].a == a && wlog[k].cyc <= c - 2) r = wlog[k].d;
    return r;
  endfunction

  task automatic step(input bit do_rst);
    logic [N-1:0] wc, rc, exr, erv;
    int           ws, rs;
    bit           busy;
    rst = do_rst;
    drive();
    #1;
    if (do_rst) begin
      wptr = 0;
      rptr = 0;
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      exp_ra = '0;
      last_rst = cyc;
      foreach (rsp_id[k]) if (k >= cyc) begin
        rsp_id.delete(k);
        rsp_dat.delete(k);
      end
    end else begin
      wc = '0;
      rc = '0;
      for (int i = 0; i < N; i++) begin
        wc[i] = v[i] && we[i];
        rc[i] = v[i] && !we[i];
      end
      ws = pick(wc, wptr);
`ifdef MEM_ARB_RAW_STALL_EN
      for (int i = 0; i < N; i++) begin
        if (rc[i] && ws >= 0 && ad[ws] == ad[i]) rc[i] = 1'b0;
        foreach (wlog[k])
          if (rc[i] && wlog[k].a == ad[i] && wlog[k].cyc > last_rst &&
              wlog[k].cyc >= cyc - (WL + 1) && wlog[k].cyc < cyc)
            rc[i] = 1'b0;
      end
`endif
      rs = pick(rc, rptr);
      exr = '0;
      if (ws >= 0) exr[ws] = 1'b1;
      if (rs >= 0) exr[rs] = 1'b1;
      chk("req_ready", bus.req_ready, exr);
      chk("mem_we", bus.mem_we, exp_we);
      if (exp_we) begin
        chk("mem_wraddr", bus.mem_wraddr, exp_wa);
        chk("mem_din", bus.mem_din, exp_wd);
      end
      chk("mem_rdaddr", bus.mem_rdaddr, exp_ra);
      erv = '0;
      if (rsp_id.exists(cyc)) erv[rsp_id[cyc]] = 1'b1;
      chk("rsp_valid", bus.rsp_valid, erv);
      if (rsp_id.exists(cyc)) chk("rsp_data", bus.rsp_data, rsp_dat[cyc]);
      busy = 1'b0;
      for (int k = cyc; k <= cyc + RL; k++)
        if (rsp_id.exists(k)) busy = 1'b1;
      chk("rd_busy", bus.rd_busy, busy);
      exp_we = (ws >= 0);
      if (ws >= 0) begin
        exp_wa = ad[ws];
        exp_wd = wd[ws];
        wlog.push_back('{cyc, ad[ws], wd[ws]});
        wptr = (ws + 1) % N;
        v[ws] = 1'b0;
      end
      if (rs >= 0) begin
        exp_ra = ad[rs];
        rsp_id[cyc + RL + 1]  = rs;
        rsp_dat[cyc + RL + 1] = ref_read(ad[rs], cyc);
        rptr = (rs + 1) % N;
        rq.push_back(rs);
        v[rs] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    int waits;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; we[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    @(negedge clk);

    // Reset, then idle with all outputs cleared.
    step(1'b1);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    idle(3);

    // Write then later read of the same address.
    v[2] = 1; we[2] = 1; ad[2] = 5; wd[2] = 32'hDEADBEEF;
    step(1'b0);
    chk("wr_pulse", bus.mem_we, 1);
    idle(5);
    v[0] = 1; we[0] = 0; ad[0] = 5;
    step(1'b0);
    idle(2);
    chk("rd_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("rd_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    idle(2);

    // All readers active: grants rotate from pointer 0.
    step(1'b1);
    rq.delete();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = 1; we[i] = 0; ad[i] = AW'(i + 1);
      end
      step(1'b0);
    end
    for (int k = 0; k < 8; k++) chk("rr_order", rq[k], k % N);
    idle(4);

    // Concurrent write (req 1) and read (req 3).
    v[1] = 1; we[1] = 1; ad[1] = 9; wd[1] = 32'hA5A5_0001;
    v[3] = 1; we[3] = 0; ad[3] = 5;
    drive();
    #1;
    chk("both_ready", bus.req_ready, 4'b1010);
    step(1'b0);
    chk("both_mem_we", bus.mem_we, 1);
    chk("both_rdaddr", bus.mem_rdaddr, 5);
    idle(4);

    // Read right after a write to the same address.
    v[1] = 1; we[1] = 1; ad[1] = 7; wd[1] = 32'h1234;
    step(1'b0);
    v[2] = 1; we[2] = 0; ad[2] = 7;
    waits = 0;
    while (v[2] && waits < 10) begin
      step(1'b0);
      if (v[2]) waits++;
    end
`ifdef MEM_ARB_RAW_STALL_EN
    chk("raw_wait", waits, WL + 1);
`else
    chk("raw_wait", waits, 0);
`endif
    idle(4);

    // Requester 0 waits behind requester 1, then pointer sits at 1.
    step(1'b1);
    v[0] = 1; we[0] = 0; ad[0] = 2;
    step(1'b0);
    v[0] = 1; v[1] = 1; we[1] = 0; ad[1] = 3;
    step(1'b0);
    chk("r0_held", v[0], 1);
    step(1'b0);
    chk("r0_granted", v[0], 0);
    v[0] = 1; v[1] = 1;
    drive();
    #1;
    chk("ptr_at_1", bus.req_ready, 4'b0010);
    step(1'b0);
    idle(5);

    // Reset while a read is in flight drops its response.
    v[0] = 1; we[0] = 0; ad[0] = 3;
    step(1'b0);
    v[0] = 0;
    step(1'b1);
    step(1'b0);
    chk("busy_after_rst", bus.rd_busy, 0);
    idle(3);

    // Random traffic on a narrow address range to force collisions.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]  = 1;
          we[i] = $urandom_range(0, 2) == 0;
          ad[i] = AW'($urandom_range(0, 7));
          wd[i] = $urandom;
        end
      step($urandom_range(0, 149) == 0);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
